conv_mac_engine: RTL and testbench
==================================

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 Parameter KER_SIZE, default 3: kernel edge; a window is KER_SIZE*KER_SIZE taps.
REQ-002 Parameter SHIFT, default 0: arithmetic right shift applied to the final sum before saturation.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  pixel/coefficient beat present.
REQ-006 in_ready  output  1  engine accepts a beat this cycle.
REQ-007 pix  input  8  unsigned image pixel read at imAddr.
REQ-008 coef  input  8  signed two's-complement kernel coefficient read at kAddr.
REQ-009 in_addr  input  16  filtered-pixel destination address; sampled on tap 0 only.
REQ-010 out_valid  output  1  filtered pixel held at output.
REQ-011 out_ready  input  1  downstream writer accepts the output.
REQ-012 out_pix  output  8  saturated filtered pixel.
REQ-013 out_addr  output  16  destination address of out_pix.
REQ-014 ovf  output  1  sticky flag; any window saturated.
REQ-015 out_cnt  output  16  count of output handshakes; wraps from 0xFFFF to 0.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high; no other condition changes tap or accumulator state.
REQ-017 Each accepted beat adds sign-extended (pix * coef), a 17-bit signed product, to a 24-bit signed accumulator, and increments the tap counter.
REQ-018 Tap counter runs 0..KER_SIZE*KER_SIZE-1; on the last tap it returns to 0 and the accumulator restarts from the next beat's product alone (no clearing cycle).
REQ-019 On the last tap, the engine shall compute (accumulator + product) >>> SHIFT, saturate it per REQ-028/029, and load it into the output register. out_valid shall go high on the following cycle (latency 1 cycle from the final accepted beat).
REQ-020 out_addr shall equal in_addr sampled at tap 0 of the same window.
REQ-021 The output register holds out_pix/out_addr stable while out_valid high and out_ready low.
REQ-022 out_valid clears after a handshake unless a new result is loaded in the same cycle; a simultaneous handshake and load shall keep out_valid high with the new data.
REQ-023 in_ready = !(tap == last && out_valid && !out_ready); non-final taps are never stalled.
REQ-024 ovf sets on the cycle a saturated result is loaded and stays set until rst.
REQ-025 out_cnt increments on every out_valid && out_ready cycle.

Reset
REQ-026 While rst is high: tap=0, accumulator=0, out_valid=0, out_pix=0, out_addr=0, ovf=0, out_cnt=0, in_ready=0; in_ready=1 the first cycle after rst falls.
REQ-027 Reset mid-window discards the partial sum; the first beat after reset is tap 0.

Configuration
REQ-028 With CONV_RELU_EN defined: results are clamped to unsigned [0,255]; negative values give 0.
REQ-029 Without CONV_RELU_EN: results are saturated to signed [-128,127] and out_pix is two's complement.

Structure
REQ-030 Package conv_pkg shall hold PIX_W=8, COEF_W=8, PROD_W=17, ACC_W=24, ADDR_W=16 constants.
REQ-031 Shift and saturation shall live in one sub-module conv_sat (combinational input sum, output value and sat flag); the controller-side address generator is unchanged.

Verification
REQ-032 pix=1, coef=1, 9 beats, in_addr=0x0042 on tap 0 -> out_pix=9, out_addr=0x0042, out_valid 1 cycle after beat 9, ovf=0.
REQ-033 pix=255, coef=127, 9 beats (sum 291465) -> out_pix=255 with CONV_RELU_EN, 127 without; ovf=1.
REQ-034 pix=10, coef=-1, 9 beats (sum -90) -> out_pix=0 with CONV_RELU_EN, 0xA6 without; ovf=1 with CONV_RELU_EN, 0 without.
REQ-035 out_ready=0 across two back-to-back windows -> in_ready low on second window's tap 8 until out_ready=1; both results delivered in order, out_cnt=2.
REQ-036 rst pulse after tap 4, then 9 beats pix=2, coef=3 -> out_pix=54; no residue from the aborted window.
REQ-037 SHIFT=2, pix=4, coef=1, 9 beats -> out_pix=9.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths for the convolution MAC engine.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 24;
    localparam int ADDR_W = 16;
    localparam int OUT_W  = 8;
endpackage

// File: rtl/conv_sat.sv
// Final shift and saturation of a window sum.
// CONV_RELU_EN selects unsigned [0,255] clamping; otherwise signed [-128,127].
module conv_sat
    import conv_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic [OUT_W-1:0]        value,
    output logic                    sat
);
    logic signed [ACC_W-1:0] shifted;

    assign shifted = sum >>> SHIFT;

`ifdef CONV_RELU_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(0);

    always_comb begin
        value = shifted[OUT_W-1:0];
        sat   = 1'b0;
        if (shifted < LO) begin
            value = '0;
            sat   = 1'b1;
        end else if (shifted > HI) begin
            value = '1;
            sat   = 1'b1;
        end
    end
`else
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(-128);

    always_comb begin
        value = shifted[OUT_W-1:0];
        sat   = 1'b0;
        if (shifted < LO) begin
            value = 8'h80;
            sat   = 1'b1;
        end else if (shifted > HI) begin
            value = 8'h7F;
            sat   = 1'b1;
        end
    end
`endif
endmodule

// File: rtl/conv_mac_engine.sv
// Streaming KER_SIZE x KER_SIZE multiply-accumulate with a one-deep output register.
// Output clamping mode is chosen in conv_sat by CONV_RELU_EN.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  pix,
    input  logic [COEF_W-1:0] coef,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_pix,
    output logic [ADDR_W-1:0] out_addr,
    output logic              ovf,
    output logic [15:0]       out_cnt
);
    localparam int TAPS  = KER_SIZE * KER_SIZE;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST = TAP_W'(TAPS - 1);

    logic [TAP_W-1:0]         tap;
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        win_addr;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]         sat_val;
    logic                     sat_flag;
    logic                     is_last, accept, load, handshake;

    // Pixel is unsigned, so widen with a zero MSB before the signed multiply.
    assign prod      = PROD_W'($signed({1'b0, pix})) * PROD_W'($signed(coef));
    assign sum       = acc + ACC_W'(prod);
    assign is_last   = (tap == LAST);
    assign in_ready  = !rst && !(is_last && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && is_last;
    assign handshake = out_valid && out_ready;

    conv_sat #(.SHIFT(SHIFT)) u_sat (
        .sum   (sum),
        .value (sat_val),
        .sat   (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tap       <= '0;
            acc       <= '0;
            win_addr  <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_addr  <= '0;
            ovf       <= 1'b0;
            out_cnt   <= '0;
        end else begin
            if (accept) begin
                if (tap == '0) win_addr <= in_addr;
                if (is_last) begin
                    tap <= '0;
                    acc <= '0;
                end else begin
                    tap <= tap + 1'b1;
                    acc <= sum;
                end
            end
            // A load in the handshake cycle replaces the departing result.
            if (load) begin
                out_pix   <= sat_val;
                out_addr  <= (tap == '0) ? in_addr : win_addr;
                ovf       <= ovf | sat_flag;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) out_cnt <= out_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized and directed checks of conv_mac_engine against a window-level model,
// run on a SHIFT=0 and a SHIFT=2 instance sharing the same stimulus.
module tb_conv_mac_engine;
    localparam int TAPS = 9;
`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  pix = '0, coef = '0;
    logic [15:0] in_addr = '0;

    logic        in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
    logic [7:0]  out_pix0, out_pix1;
    logic [15:0] out_addr0, out_addr1, out_cnt0, out_cnt1;

    always #5 clk = ~clk;

    conv_mac_engine #(.KER_SIZE(3), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .pix(pix), .coef(coef), .in_addr(in_addr),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pix(out_pix0),
        .out_addr(out_addr0), .ovf(ovf0), .out_cnt(out_cnt0)
    );

    conv_mac_engine #(.KER_SIZE(3), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .pix(pix), .coef(coef), .in_addr(in_addr),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pix(out_pix1),
        .out_addr(out_addr1), .ovf(ovf1), .out_cnt(out_cnt1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          pix0;
        int          pix1;
        logic [15:0] addr;
    } res_t;

    res_t        q[$];
    int          tap_m = 0;
    int          sum_m = 0;
    int          cnt_m = 0;
    logic [15:0] addr_m = '0;
    bit          ovf_m0 = 0, ovf_m1 = 0;
    logic [7:0]  got_pix0, got_pix1;
    logic [15:0] got_addr;

    function automatic int satm(input int s, input int sh, output bit o);
        int v = s >>> sh;
        o = 1'b0;
        if (RELU) begin
            if (v < 0)   begin o = 1'b1; return 0;   end
            if (v > 255) begin o = 1'b1; return 255; end
        end else begin
            if (v < -128) begin o = 1'b1; return -128; end
            if (v > 127)  begin o = 1'b1; return 127;  end
        end
        return v;
    endfunction

    task automatic step(input bit v, input logic [7:0] p, input logic [7:0] c,
                        input logic [15:0] a, input bit ordy);
        bit   rdy, o0, o1;
        res_t r;
        @(negedge clk);
        in_valid = v; pix = p; coef = c; in_addr = a; out_ready = ordy;
        #1;
        rdy = !(tap_m == TAPS - 1 && q.size() > 0 && !ordy);
        check("in_ready0", in_ready0, rdy);
        check("in_ready1", in_ready1, rdy);
        check("out_valid0", out_valid0, q.size() > 0);
        check("out_valid1", out_valid1, q.size() > 0);
        check("ovf0", ovf0, ovf_m0);
        check("ovf1", ovf1, ovf_m1);
        check("out_cnt0", out_cnt0, cnt_m[15:0]);
        if (q.size() > 0 && ordy) begin
            r = q.pop_front();
            check("out_pix0", out_pix0, r.pix0[7:0]);
            check("out_pix1", out_pix1, r.pix1[7:0]);
            check("out_addr0", out_addr0, r.addr);
            check("out_addr1", out_addr1, r.addr);
            got_pix0 = out_pix0; got_pix1 = out_pix1; got_addr = out_addr0;
            cnt_m++;
        end
        if (v && rdy) begin
            sum_m += int'(p) * int'($signed(c));
            if (tap_m == 0) addr_m = a;
            if (tap_m == TAPS - 1) begin
                r.pix0 = satm(sum_m, 0, o0);
                r.pix1 = satm(sum_m, 2, o1);
                r.addr = addr_m;
                q.push_back(r);
                ovf_m0 |= o0;
                ovf_m1 |= o1;
                tap_m = 0;
                sum_m = 0;
            end else begin
                tap_m++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; pix = 8'hFF; coef = 8'h7F; out_ready = 1'b0;
        #1 check("rst_in_ready", in_ready0, 1'b0);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_out_pix", out_pix0, 8'h00);
        check("rst_out_addr", out_addr0, 16'h0000);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_out_cnt", out_cnt0, 16'h0000);
        check("rst_in_ready_hold", in_ready0, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1 check("post_rst_in_ready", in_ready0, 1'b1);
        q.delete();
        tap_m = 0; sum_m = 0; cnt_m = 0; ovf_m0 = 0; ovf_m1 = 0;
    endtask

    task automatic window(input logic [7:0] p, input logic [7:0] c, input logic [15:0] a);
        for (int i = 0; i < TAPS; i++) step(1'b1, p, c, (i == 0) ? a : 16'hDEAD, 1'b1);
        step(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    endtask

    initial begin
        do_reset();

        window(8'd1, 8'd1, 16'h0042);
        check("r32_pix", got_pix0, 8'd9);
        check("r32_addr", got_addr, 16'h0042);
        check("r32_ovf", ovf0, 1'b0);

        window(8'd255, 8'd127, 16'h1234);
        check("r33_pix", got_pix0, RELU ? 8'd255 : 8'd127);
        check("r33_ovf", ovf0, 1'b1);

        do_reset();
        window(8'd10, 8'hFF, 16'h0007);
        check("r34_pix", got_pix0, RELU ? 8'h00 : 8'hA6);
        check("r34_ovf", ovf0, RELU ? 1'b1 : 1'b0);

        do_reset();
        window(8'd4, 8'd1, 16'h0009);
        check("r37_pix_shift2", got_pix1, 8'd9);

        do_reset();
        for (int i = 0; i < TAPS; i++) step(1'b1, 8'd3, 8'd3, (i == 0) ? 16'h0100 : 16'h0, 1'b0);
        for (int i = 0; i < TAPS; i++) step(1'b1, 8'd2, 8'd5, (i == 0) ? 16'h0200 : 16'h0, 1'b0);
        check("r35_stall", in_ready0, 1'b0);
        step(1'b1, 8'd2, 8'd5, 16'h0, 1'b0);
        check("r35_stall_hold", in_ready0, 1'b0);
        step(1'b1, 8'd2, 8'd5, 16'h0, 1'b1);
        check("r35_first_addr", got_addr, 16'h0100);
        check("r35_first_pix", got_pix0, 8'd81);
        step(1'b0, 8'd0, 8'd0, 16'h0, 1'b1);
        check("r35_second_addr", got_addr, 16'h0200);
        check("r35_second_pix", got_pix0, RELU ? 8'd90 : 8'd90);
        step(1'b0, 8'd0, 8'd0, 16'h0, 1'b1);
        check("r35_cnt", out_cnt0, 16'd2);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'd7, 8'd9, 16'h0EEE, 1'b1);
        do_reset();
        window(8'd2, 8'd3, 16'h0036);
        check("r36_pix", got_pix0, 8'd54);
        check("r36_addr", got_addr, 16'h0036);

        do_reset();
        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 9) < 8, 8'($urandom), 8'($urandom),
                 16'($urandom), $urandom_range(0, 9) < 7);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 16'h0, 1'b1);
        check("rand_drained", out_valid0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
